// File: rtl/counter_pair_monitor.sv
// Checks that two free-running counters only hold or step by one, registers their
// wrapped sum, and drives a timed reset request whenever that sum crosses THRESH.
module counter_pair_monitor #(
   parameter int SIZE    = 8,
   parameter int THRESH  = 8,
   parameter int INIT1   = 0,
   parameter int INIT2   = 1,
   parameter int RST_LEN = 2,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SIZE-1:0]  val1,
   input  logic [SIZE-1:0]  val2,
   output logic [SIZE-1:0]  sum,
   output logic             rst_req,
   output logic             busy,
   output logic             err,
   output logic [2:0]       err_code,
   output logic [CNT_W-1:0] rst_cnt
);

   typedef enum logic [1:0] {S_INIT, S_TRACK, S_REQ, S_WAIT} state_t;

   localparam int RW = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [RW-1:0]   REQ_LAST  = RW'(RST_LEN - 1);
   localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);
   localparam logic [SIZE-1:0] INIT1_V   = SIZE'(INIT1);
   localparam logic [SIZE-1:0] INIT2_V   = SIZE'(INIT2);
   localparam logic [SIZE:0]   THRESH_V  = (SIZE+1)'(THRESH);

   state_t          state;
   logic [SIZE-1:0] prev1, prev2;
   logic [RW-1:0]   reqCount;
   logic [WW-1:0]   waitCount;

   logic [SIZE-1:0] curSum, step1, step2;
   logic            recovering, bad1, bad2, match, crossing, timeoutHit;
   logic [2:0]      newCode;

   // A counter snapping back to its init value is only legal while we are asking for it.
   always_comb begin
      curSum     = val1 + val2;
      step1      = val1 - prev1;
      step2      = val2 - prev2;
      recovering = (state == S_REQ) || (state == S_WAIT);
      bad1       = (state != S_INIT) && (step1 > SIZE'(1)) && !(recovering && (val1 == INIT1_V));
      bad2       = (state != S_INIT) && (step2 > SIZE'(1)) && !(recovering && (val2 == INIT2_V));
      match      = (val1 == INIT1_V) && (val2 == INIT2_V);
      crossing   = ({1'b0, curSum} > THRESH_V);
      timeoutHit = (state == S_WAIT) && !match && (waitCount == WAIT_LAST);
      newCode    = err_code | {timeoutHit, bad2, bad1};
   end

   // Datapath registers and the request/wait sequencer share one clocked block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_INIT;
         sum       <= '0;
         rst_req   <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         err_code  <= '0;
         rst_cnt   <= '0;
         prev1     <= '0;
         prev2     <= '0;
         reqCount  <= '0;
         waitCount <= '0;
      end else begin
         sum      <= curSum;
         prev1    <= val1;
         prev2    <= val2;
         err_code <= newCode;
         err      <= |newCode;
         case (state)
            S_INIT: state <= S_TRACK;
            S_TRACK: begin
               if (crossing) begin
                  state    <= S_REQ;
                  rst_req  <= 1'b1;
                  busy     <= 1'b1;
                  reqCount <= '0;
               end
            end
            S_REQ: begin
               if (reqCount == REQ_LAST) begin
                  state     <= S_WAIT;
                  rst_req   <= 1'b0;
                  waitCount <= '0;
               end else begin
                  reqCount <= reqCount + RW'(1);
               end
            end
            S_WAIT: begin
               // A match on the final timeout cycle still counts as a completed reset.
               if (match) begin
                  state <= S_TRACK;
                  busy  <= 1'b0;
                  if (rst_cnt != '1)
                     rst_cnt <= rst_cnt + CNT_W'(1);
               end else if (timeoutHit) begin
                  state    <= S_REQ;
                  rst_req  <= 1'b1;
                  reqCount <= '0;
               end else begin
                  waitCount <= waitCount + WW'(1);
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_pair_monitor.sv
// Directed bench for counter_pair_monitor: a per-sample behavioural model checked
// every cycle, plus hand-computed expectations along the scripted scenarios.
module tb_counter_pair_monitor;

   localparam int SIZE    = 8;
   localparam int THRESH  = 8;
   localparam int INIT1   = 0;
   localparam int INIT2   = 1;
   localparam int RST_LEN = 2;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 8;

   logic             clk;
   logic             rst;
   logic [SIZE-1:0]  val1, val2;
   logic [SIZE-1:0]  sum;
   logic             rst_req, busy, err;
   logic [2:0]       err_code;
   logic [CNT_W-1:0] rst_cnt;

   int assertions = 0;
   int failures   = 0;
   bit checkOn    = 0;

   // Model state: how many request cycles remain, whether we await the init values, and for how long.
   bit mFirst;
   int reqLeft, waitAge, mPrev1, mPrev2;
   bit waiting;
   int expSum, expCode, expCnt;

   counter_pair_monitor #(
      .SIZE(SIZE), .THRESH(THRESH), .INIT1(INIT1), .INIT2(INIT2),
      .RST_LEN(RST_LEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .val1(val1), .val2(val2), .sum(sum),
      .rst_req(rst_req), .busy(busy), .err(err), .err_code(err_code), .rst_cnt(rst_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit legalStep(int v, int p, int initV, bit recovering);
      int d;
      d = (v - p) & ((1 << SIZE) - 1);
      return (d <= 1) || (recovering && v == initV);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertions++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input int v1, input int v2);
      @(negedge clk);
      val1 = SIZE'(v1);
      val2 = SIZE'(v2);
      @(posedge clk);
      #1;
   endtask

   // Behavioural model, advanced once per sampled cycle.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mFirst = 1; reqLeft = 0; waiting = 0; waitAge = 0;
            mPrev1 = 0; mPrev2 = 0; expSum = 0; expCode = 0; expCnt = 0;
         end else begin
            int v1, v2, s;
            bit rec;
            v1  = int'(val1);
            v2  = int'(val2);
            s   = (v1 + v2) % (1 << SIZE);
            rec = (reqLeft > 0) || waiting;
            if (!mFirst) begin
               if (!legalStep(v1, mPrev1, INIT1, rec)) expCode |= 1;
               if (!legalStep(v2, mPrev2, INIT2, rec)) expCode |= 2;
            end
            if (mFirst) begin
               mFirst = 0;
            end else if (reqLeft > 0) begin
               reqLeft--;
               if (reqLeft == 0) begin
                  waiting = 1;
                  waitAge = 0;
               end
            end else if (waiting) begin
               waitAge++;
               if (v1 == INIT1 && v2 == INIT2) begin
                  waiting = 0;
                  if (expCnt < (1 << CNT_W) - 1) expCnt++;
               end else if (waitAge == TIMEOUT) begin
                  expCode |= 4;
                  waiting = 0;
                  reqLeft = RST_LEN;
               end
            end else if (s > THRESH) begin
               reqLeft = RST_LEN;
            end
            expSum = s;
            mPrev1 = v1;
            mPrev2 = v2;
         end
      end
   end

   // Continuous comparison, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (checkOn) begin
            checkOutput("model_sum", sum, expSum);
            checkOutput("model_rst_req", rst_req, (reqLeft > 0));
            checkOutput("model_busy", busy, (reqLeft > 0) || waiting);
            checkOutput("model_err_code", err_code, expCode);
            checkOutput("model_err", err, (expCode != 0));
            checkOutput("model_rst_cnt", rst_cnt, expCnt);
         end
      end
   end

   initial begin
      rst = 1'b1; val1 = '0; val2 = 8'd1;
      #12;
      checkOutput("reset_sum", sum, 0);
      checkOutput("reset_rst_req", rst_req, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_err_code", err_code, 0);
      checkOutput("reset_rst_cnt", rst_cnt, 0);
      checkOn = 1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("init_sum", sum, 1);

      // Counting up until the sum crosses the threshold.
      applyStimulus(1, 2); checkOutput("t1_sum3", sum, 3);
      applyStimulus(2, 3); checkOutput("t1_sum5", sum, 5);
      applyStimulus(3, 4); checkOutput("t1_no_req", rst_req, 0);
      applyStimulus(4, 5); checkOutput("t1_sum9", sum, 9); checkOutput("t1_req_rise", rst_req, 1);
      checkOutput("t1_busy", busy, 1);
      applyStimulus(4, 5); checkOutput("t1_req_hold", rst_req, 1);
      applyStimulus(4, 5); checkOutput("t1_req_fall", rst_req, 0); checkOutput("t1_busy_wait", busy, 1);

      // Counters return to init values while waiting.
      applyStimulus(4, 5);
      applyStimulus(0, 1);
      checkOutput("t2_rst_cnt", rst_cnt, 1);
      checkOutput("t2_busy", busy, 0);
      checkOutput("t2_err", err, 0);

      // Counter 1 skips a value; the error is sticky and the checker resyncs.
      applyStimulus(1, 1);
      applyStimulus(2, 1);
      applyStimulus(3, 1);
      applyStimulus(5, 1); checkOutput("t3_code", err_code, 1); checkOutput("t3_err", err, 1);
      applyStimulus(6, 1); checkOutput("t3_sticky", err_code, 1); checkOutput("t3_sum7", sum, 7);

      // Counters never come back: timeout then re-request.
      applyStimulus(7, 2); checkOutput("t4_req", rst_req, 1);
      applyStimulus(7, 3);
      applyStimulus(7, 4); checkOutput("t4_wait", rst_req, 0);
      applyStimulus(7, 5);
      applyStimulus(7, 6);
      for (int i = 0; i < 13; i++) applyStimulus(7, 7);
      checkOutput("t4_pre_timeout_req", rst_req, 0);
      checkOutput("t4_pre_timeout_code", err_code, 1);
      applyStimulus(7, 7);
      checkOutput("t4_timeout_code", err_code, 5);
      checkOutput("t4_rereq", rst_req, 1);
      checkOutput("t4_cnt_kept", rst_cnt, 1);
      applyStimulus(7, 7); checkOutput("t4_rereq_hold", rst_req, 1);
      applyStimulus(7, 7); checkOutput("t4_rereq_fall", rst_req, 0);
      applyStimulus(0, 1); checkOutput("t4_rst_cnt2", rst_cnt, 2); checkOutput("t4_busy", busy, 0);

      // Asynchronous reset in the middle of a request.
      applyStimulus(1, 2);
      applyStimulus(2, 3);
      applyStimulus(3, 4);
      applyStimulus(4, 5); checkOutput("t6_req", rst_req, 1);
      #1 rst = 1'b1;
      #1;
      checkOutput("t6_req_async", rst_req, 0);
      checkOutput("t6_busy", busy, 0);
      checkOutput("t6_code", err_code, 0);
      checkOutput("t6_cnt", rst_cnt, 0);
      checkOutput("t6_sum", sum, 0);
      repeat (2) @(negedge clk);
      val1 = 8'hFE; val2 = 8'h02; rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("t6_init_no_err", err_code, 0);
      checkOutput("t5_sum_wrap0", sum, 0);

      // Wrap of counter 1 is a legal step and wrapped sums stay low.
      applyStimulus(8'hFF, 2); checkOutput("t5_sum1", sum, 1); checkOutput("t5_no_err", err_code, 0);
      applyStimulus(8'h00, 2); checkOutput("t5_sum2", sum, 2); checkOutput("t5_wrap_ok", err_code, 0);
      applyStimulus(8'h01, 2); checkOutput("t5_sum3", sum, 3); checkOutput("t5_no_req", rst_req, 0);
      checkOutput("t5_not_busy", busy, 0);
      applyStimulus(8'h01, 2);

      @(negedge clk);
      checkOn = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/counter_pair_monitor.md
# counter_pair_monitor

Single-clock reader/checker for the dual-counter sum datapath. It samples two free-running counter values each `clk` and checks that each counter only holds or increments by one (mod 2^SIZE). It registers their wrapped sum and issues a timed reset request when the sum exceeds a threshold. It then waits for both counters to return to their init values, counts completed reset cycles, and records protocol violations in sticky error bits.

## Interface
- `SIZE`, 8, counter/sum width
- `THRESH`, 8, reset request when sum > THRESH (unsigned)
- `INIT1`, 0, expected post-reset value of counter 1
- `INIT2`, 1, expected post-reset value of counter 2
- `RST_LEN`, 2, cycles `rst_req` stays high per request (≥1)
- `TIMEOUT`, 16, max cycles in WAIT before re-request (≥1)
- `CNT_W`, 8, width of `rst_cnt`

Ports:
- `clk`, in, 1, clock
- `rst`, in, 1, reset, asynchronous, active-high
- `val1`, in, SIZE, counter 1 value
- `val2`, in, SIZE, counter 2 value
- `sum`, out, SIZE, registered (val1+val2) mod 2^SIZE
- `rst_req`, out, 1, reset request to the counters
- `busy`, out, 1, high in REQ or WAIT
- `err`, out, 1, sticky, OR of `err_code`
- `err_code`, out, 3, sticky bitmask: [0] counter-1 step error, [1] counter-2 step error, [2] WAIT timeout
- `rst_cnt`, out, CNT_W, completed reset cycles, saturating

## Operation
- States:
  - INIT: first sample after reset. Loads `prev1`/`prev2`; no step check.
  - TRACK: normal monitoring.
  - REQ: `rst_req` high.
  - WAIT: waiting for both counters to show their init values.
- Step check, every cycle in TRACK/REQ/WAIT: `d = val − prev` mod 2^SIZE.
  - Legal: `d` = 0 or 1.
  - Also legal in REQ/WAIT: `val` == its INIT.
  - Illegal: set the corresponding `err_code` bit.
  - `prev` always updates to `val`, so the checker resyncs.
  - Wrap 2^SIZE−1 → 0 is legal (`d` = 1).
- Sum: computed modulo 2^SIZE, carry discarded. `sum` is registered every cycle in all states.
- INIT → TRACK unconditionally after one cycle.
- TRACK → REQ when the wrapped sum of the current sample is > THRESH.
  - Compare uses the wrapped sum: 0xFF + 0x02 = 0x01 does not trigger.
- REQ: lasts exactly RST_LEN cycles, then → WAIT. Step check still active.
- WAIT → TRACK when `val1` == INIT1 and `val2` == INIT2 in the same sample; `rst_cnt` += 1, saturating at 2^CNT_W−1.
- WAIT: if TIMEOUT cycles elapse without a match, set `err_code[2]` and → REQ to re-request. `rst_cnt` is not incremented.
- Errors never stop monitoring. They clear only on `rst`.
- Simultaneous events:
  - A step error and a threshold crossing in the same TRACK cycle both take effect (bit set and → REQ).
  - A WAIT match and timeout expiry in the same cycle: the match wins.

## Timing
- Values on reset (async assert):
  - `state` = INIT
  - `sum` = 0
  - `rst_req` = 0
  - `busy` = 0
  - `err` = 0
  - `err_code` = 0
  - `rst_cnt` = 0
  - `prev1` = `prev2` = 0
  - timers = 0
- Reset release: the first rising `clk` edge with `rst` low is the INIT sample.
- `sum` latency: 1 cycle from input sample.
- `rst_req`:
  - Rises at the edge after the threshold-crossing sample, which is the same edge the FSM enters REQ.
  - High for exactly RST_LEN cycles, low on entry to WAIT.
- The WAIT timer starts at 0 on WAIT entry and counts sampled cycles. Timeout fires on the edge ending cycle TIMEOUT.
- `err`/`err_code` update 1 cycle after the offending sample.
- `rst_cnt` updates on the WAIT → TRACK edge.
- `rst` asserted mid-REQ/WAIT: `rst_req` drops immediately (async), and the FSM restarts at INIT.

## Test plan
1. Reset, then both counters step 0/1 → 1/2 → … with THRESH=8: `sum` follows 1 cycle late; `rst_req` rises the cycle after the sample 4/5 (sum 9) and stays high 2 cycles; `busy`=1.
2. After (1), drive `val1`=0, `val2`=1 two cycles into WAIT: → TRACK, `rst_cnt`=1, `busy`=0, `err`=0.
3. In TRACK, `val1` jumps 3 → 5: `err_code`=3'b001, `err`=1, sticky through later legal traffic; `prev1`=5, so 5 → 6 raises no new error.
4. Enter WAIT and hold `val1`=7, `val2`=7 (TIMEOUT=16): after 16 cycles `err_code[2]`=1, `rst_req` pulses again for 2 cycles, `rst_cnt` unchanged.
5. SIZE=8, THRESH=8, `val1` 0xFE→0xFF→0x00, `val2`=0x02 constant: no step error at wrap; sums 0x00/0x01/0x02 (wrapped) never trigger `rst_req`.
6. Assert `rst` during REQ: `rst_req` goes low without waiting for `clk`, all outputs return to reset values, and the next sample is treated as INIT with no step error.
